alu4_nibble_seq: RTL and testbench

Multi-nibble sequencer that sits directly upstream of the 4-bit ALU and extends it to NIBBLES×4-bit operands. Operands are loaded one nibble at a time into internal A/B registers. The block then presents one nibble pair per cycle to the ALU, least-significant first, chaining the ALU carry-out back into carry-in. It gathers the ALU sum nibbles into a full-width result and reports aggregate carry, zero and overflow flags.

---
 rtl/alu4_nibble_seq.sv | 168 ++++++++++++++++
 tb/tb_alu4_nibble_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu4_nibble_seq.sv
// alu4_nibble_seq
// Sequencer in front of a combinational 4-bit ALU. It widens the ALU to
// NIBBLES x 4-bit operands by running one nibble per cycle, least-significant
// nibble first, and feeding each ALU carry-out back in as the next carry-in.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   ena                   advance enable; all state holds while low
//   din, ld_a, ld_b       nibble-serial operand loads (shift in at the top)
//   start, op, b_inv, cin operation request (accepted in IDLE only)
//   alu_a, alu_b, alu_y,
//   alu_op, alu_b_inv     per-nibble drive to the ALU
//   alu_s, alu_c,
//   alu_zero, alu_overflow  ALU results for the presented nibble
//   res                   assembled result (valid from done onward)
//   c_out, zero_out,
//   ovf_out               aggregate flags
//   busy, done, err       status; done/err are one-cycle pulses
module alu4_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [3:0]           din,
  input  logic                 ld_a,
  input  logic                 ld_b,
  input  logic                 start,
  input  logic [5:0]           op,
  input  logic                 b_inv,
  input  logic                 cin,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic                 alu_y,
  output logic [5:0]           alu_op,
  output logic                 alu_b_inv,
  input  logic [3:0]           alu_s,
  input  logic                 alu_c,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  output logic [4*NIBBLES-1:0] res,
  output logic                 c_out,
  output logic                 zero_out,
  output logic                 ovf_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [IDX_W-1:0] idx;
  logic [5:0]       op_q;
  logic             b_inv_q;
  logic             cin_q;
  logic             carry_q;
  logic             zacc;

  logic [W-1:0]     a_sh;
  logic [W-1:0]     b_sh;
  logic             op_illegal;

  // LSR B mode and MSB sign-fill carry mode cannot be chained across nibbles.
  assign op_illegal = (op[5:4] == 2'd3) || (op[3:2] == 2'd3);

  assign a_sh = a_reg >> {idx, 2'b00};
  assign b_sh = b_reg >> {idx, 2'b00};

  // ---- ALU drive (combinational from the current nibble index) ----
  always_comb begin
    alu_a     = a_reg[3:0];
    alu_b     = b_reg[3:0];
    alu_y     = 1'b0;
    alu_op    = 6'd0;
    alu_b_inv = 1'b0;
    if (state == RUN) begin
      alu_a       = a_sh[3:0];
      alu_b       = b_sh[3:0];
      alu_b_inv   = b_inv_q;
      alu_op[1:0] = op_q[1:0];
      if (idx == '0) begin
        alu_op[3:2] = op_q[3:2];
        alu_op[5:4] = op_q[5:4];
        alu_y       = cin_q;
      end else begin
        // Upper nibbles always chain the carry; an LSB constant only lives
        // in nibble 0, so the remaining nibbles see a cleared B.
        alu_op[3:2] = 2'd0;
        alu_op[5:4] = (op_q[5:4] == 2'd1) ? 2'd2 : op_q[5:4];
        alu_y       = carry_q;
      end
    end
  end

  // ---- sequencer state, operand and result registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      res      <= '0;
      idx      <= '0;
      op_q     <= '0;
      b_inv_q  <= 1'b0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      zacc     <= 1'b1;
      c_out    <= 1'b0;
      zero_out <= 1'b0;
      ovf_out  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (ena) begin
        case (state)
          IDLE: begin
            // Loads land at the same edge as start, so a run started
            // together with a load uses the freshly shifted operand.
            if (ld_a) a_reg <= {din, a_reg[W-1:4]};
            if (ld_b) b_reg <= {din, b_reg[W-1:4]};
            if (start) begin
              if (op_illegal) begin
                done <= 1'b1;
                err  <= 1'b1;
              end else begin
                op_q    <= op;
                b_inv_q <= b_inv;
                cin_q   <= cin;
                idx     <= '0;
                zacc    <= 1'b1;
                busy    <= 1'b1;
                state   <= RUN;
              end
            end
          end
          RUN: begin
            res     <= {alu_s, res[W-1:4]};
            carry_q <= alu_c;
            zacc    <= zacc & alu_zero;
            if (idx == LAST) begin
              c_out    <= alu_c;
              ovf_out  <= alu_overflow;
              zero_out <= zacc & alu_zero;
              done     <= 1'b1;
              busy     <= 1'b0;
              idx      <= '0;
              state    <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu4_nibble_seq.sv
module tb_alu4_nibble_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic [3:0]  din = 4'd0;
  logic        ld_a = 1'b0;
  logic        ld_b = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  op = 6'd0;
  logic        b_inv = 1'b0;
  logic        cin = 1'b0;
  logic [3:0]  alu_a, alu_b;
  logic        alu_y;
  logic [5:0]  alu_op;
  logic        alu_b_inv;
  logic [3:0]  alu_s;
  logic        alu_c, alu_zero, alu_overflow;
  logic [15:0] res;
  logic        c_out, zero_out, ovf_out, busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu4_nibble_seq #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .ld_a(ld_a), .ld_b(ld_b),
    .start(start), .op(op), .b_inv(b_inv), .cin(cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_op(alu_op),
    .alu_b_inv(alu_b_inv), .alu_s(alu_s), .alu_c(alu_c), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .res(res), .c_out(c_out), .zero_out(zero_out),
    .ovf_out(ovf_out), .busy(busy), .done(done), .err(err)
  );

  // Behavioural 4-bit ALU the sequencer drives.
  // B mode: 0 pass, 1 constant 1 (LSB), 2 clear, 3 LSR; then optional invert.
  // Carry mode: 0 use alu_y, 1 one, 2 zero, 3 MSB of A.
  // Function: 0 add, 1 and, 2 or, 3 xor.
  logic [3:0] m_b;
  logic       m_ci;
  logic [4:0] m_sum;
  always_comb begin
    m_b = alu_b;
    case (alu_op[5:4])
      2'd0:    m_b = alu_b;
      2'd1:    m_b = 4'd1;
      2'd2:    m_b = 4'd0;
      default: m_b = {1'b0, alu_b[3:1]};
    endcase
    if (alu_b_inv) m_b = ~m_b;
    case (alu_op[3:2])
      2'd0:    m_ci = alu_y;
      2'd1:    m_ci = 1'b1;
      2'd2:    m_ci = 1'b0;
      default: m_ci = alu_a[3];
    endcase
    m_sum = {1'b0, alu_a} + {1'b0, m_b} + {4'd0, m_ci};
    alu_s = m_sum[3:0];
    alu_c = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op[1:0])
      2'd0: begin
        alu_s = m_sum[3:0];
        alu_c = m_sum[4];
        alu_overflow = (alu_a[3] == m_b[3]) && (m_sum[3] != alu_a[3]);
      end
      2'd1:    alu_s = alu_a & m_b;
      2'd2:    alu_s = alu_a | m_b;
      default: alu_s = alu_a ^ m_b;
    endcase
    alu_zero = (alu_s == 4'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Operands are shifted in at the top, so the least-significant nibble
  // goes first and ends up in nibble 0 after four loads.
  task automatic load_ab(input logic [15:0] a, input logic [15:0] b);
    for (int k = 0; k < 4; k++) begin
      din = a[4*k +: 4]; ld_a = 1'b1;
      step();
      ld_a = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      din = b[4*k +: 4]; ld_b = 1'b1;
      step();
      ld_b = 1'b0;
    end
  endtask

  task automatic start_run(input logic [5:0] o, input logic bi, input logic ci);
    op = o; b_inv = bi; cin = ci; start = 1'b1;
  endtask

  // Crosses the start edge, then waits (bounded) for done and checks the run.
  task automatic wait_done(input string name, input logic poke_ld,
                           input logic [15:0] er, input logic ec,
                           input logic ez, input logic ev);
    int cnt;
    step();
    start = 1'b0;
    cnt = 1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s_busy: got %b expected 1", name, busy);
    end
    if (poke_ld) begin
      din = 4'hF; ld_a = 1'b1;
      step(); cnt++;
      ld_a = 1'b0;
    end
    while (done !== 1'b1 && cnt < 20) begin
      step(); cnt++;
    end
    checks++;
    if (cnt !== 5) begin
      errors++; $display("FAIL %s_latency: got %0d cycles expected 5", name, cnt);
    end
    checks++;
    if (res !== er) begin
      errors++; $display("FAIL %s_res: got %h expected %h", name, res, er);
    end
    checks++;
    if ({c_out, zero_out, ovf_out, err, busy} !== {ec, ez, ev, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s_flags: got c=%b z=%b v=%b err=%b busy=%b expected c=%b z=%b v=%b err=0 busy=0",
               name, c_out, zero_out, ovf_out, err, busy, ec, ez, ev);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    checks++;
    if ({busy, done, err, c_out, zero_out, ovf_out} !== 6'b0 || res !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b err=%b c=%b z=%b v=%b res=%h expected all 0",
               busy, done, err, c_out, zero_out, ovf_out, res);
    end
    checks++;
    if ({alu_a, alu_b, alu_y, alu_op, alu_b_inv} !== 16'h0) begin
      errors++;
      $display("FAIL reset_alu_drive: got a=%h b=%h y=%b op=%h binv=%b expected 0",
               alu_a, alu_b, alu_y, alu_op, alu_b_inv);
    end
  endtask

  task automatic test_add();
    load_ab(16'h1234, 16'h0FFF);
    start_run(6'h00, 1'b0, 1'b0);
    wait_done("add_basic", 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    load_ab(16'hFFFF, 16'h0001);
    start_run(6'h00, 1'b0, 1'b0);
    wait_done("add_wrap", 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_sub();
    load_ab(16'h0005, 16'h0007);
    start_run(6'h04, 1'b1, 1'b0);
    wait_done("sub_neg", 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    load_ab(16'h7FFF, 16'h0001);
    start_run(6'h00, 1'b0, 1'b0);
    wait_done("add_ovf", 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reject();
    start_run(6'h30, 1'b0, 1'b0);
    step();
    start = 1'b0;
    checks++;
    if ({done, err, busy} !== 3'b110) begin
      errors++; $display("FAIL reject_lsr: got done=%b err=%b busy=%b expected 1 1 0", done, err, busy);
    end
    checks++;
    if (res !== 16'h8000 || ovf_out !== 1'b1) begin
      errors++; $display("FAIL reject_hold: got res=%h v=%b expected 8000 1", res, ovf_out);
    end
    step();
    checks++;
    if ({done, err, busy} !== 3'b000) begin
      errors++; $display("FAIL reject_pulse: got done=%b err=%b busy=%b expected 0 0 0", done, err, busy);
    end
    start_run(6'h0C, 1'b0, 1'b0);
    step();
    start = 1'b0;
    checks++;
    if ({done, err, busy} !== 3'b110) begin
      errors++; $display("FAIL reject_msb: got done=%b err=%b busy=%b expected 1 1 0", done, err, busy);
    end
    step();
  endtask

  task automatic test_inc_dec();
    load_ab(16'h00FF, 16'h5A5A);
    start_run(6'h24, 1'b0, 1'b0);
    wait_done("inc", 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    load_ab(16'h0100, 16'h5A5A);
    start_run(6'h14, 1'b1, 1'b0);
    wait_done("dec", 1'b0, 16'h00FF, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_ld_busy();
    load_ab(16'h1234, 16'h0000);
    start_run(6'h00, 1'b0, 1'b0);
    wait_done("ld_busy_run", 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    start_run(6'h00, 1'b0, 1'b0);
    wait_done("ld_busy_after", 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    load_ab(16'h1234, 16'h0FFF);
    start_run(6'h00, 1'b0, 1'b0);
    wait_done("b2b_first", 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    start_run(6'h04, 1'b1, 1'b0);
    wait_done("b2b_second", 1'b0, 16'h0235, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    int cnt;
    load_ab(16'h1234, 16'h0FFF);
    start_run(6'h00, 1'b0, 1'b0);
    step();
    start = 1'b0;
    step();
    cnt = 2;
    ena = 1'b0;
    repeat (3) begin
      step(); cnt++;
    end
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL stall_hold: got busy=%b done=%b expected 1 0", busy, done);
    end
    ena = 1'b1;
    while (done !== 1'b1 && cnt < 20) begin
      step(); cnt++;
    end
    checks++;
    if (cnt !== 8) begin
      errors++; $display("FAIL stall_latency: got %0d cycles expected 8", cnt);
    end
    checks++;
    if (res !== 16'h2233 || c_out !== 1'b0) begin
      errors++; $display("FAIL stall_res: got res=%h c=%b expected 2233 0", res, c_out);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    load_ab(16'h1234, 16'h0FFF);
    start_run(6'h00, 1'b0, 1'b0);
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({busy, done, err, c_out, zero_out, ovf_out} !== 6'b0 || res !== 16'h0) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%b done=%b err=%b c=%b z=%b v=%b res=%h expected all 0",
               busy, done, err, c_out, zero_out, ovf_out, res);
    end
    checks++;
    if ({alu_a, alu_b, alu_y, alu_op, alu_b_inv} !== 16'h0) begin
      errors++;
      $display("FAIL midrun_alu_drive: got a=%h b=%h y=%b op=%h binv=%b expected 0",
               alu_a, alu_b, alu_y, alu_op, alu_b_inv);
    end
    seen = 0;
    repeat (8) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midrun_no_done: got %0d active cycles expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_reject();
    test_inc_dec();
    test_ld_busy();
    test_back_to_back();
    test_stall();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
